// File: rtl/red_pitaya_asg_sweep.sv
// Frequency-sweep sequencer for one ASG channel: ramps the channel pointer step
// from start to stop with a programmable dwell per value (single, sawtooth, triangle).
module red_pitaya_asg_sweep #(
  parameter int unsigned RSZ = 14
) (
  input  logic              dac_clk_i,
  input  logic              dac_rstn_i,
  input  logic              sw_start_i,
  input  logic              sw_stop_i,
  input  logic              trig_i,
  input  logic              set_ext_i,
  input  logic [1:0]        set_mode_i,
  input  logic [RSZ+15:0]   set_start_i,
  input  logic [RSZ+15:0]   set_stop_i,
  input  logic [RSZ+15:0]   set_inc_i,
  input  logic [31:0]       set_dwell_i,
  output logic [RSZ+15:0]   step_o,
  output logic              step_upd_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              dir_o
);

  localparam int unsigned SW = RSZ + 16;
  localparam int unsigned AW = SW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  step_d;
  logic [SW-1:0]  start_q, start_d, stop_q, stop_d, inc_q, inc_d;
  logic [1:0]     mode_q, mode_d;
  logic [31:0]    dwell_q, dwell_d, cnt_q, cnt_d;
  logic [31:0]    dwell_new;
  logic [SW-1:0]  tgt;
  logic           dir_d, back_q, back_d, upd_d, done_d, busy_d;

  // One advance toward tgt, clamped so the target is never overshot.
  function automatic logic [SW-1:0] advance(input logic [SW-1:0] cur,
                                            input logic [SW-1:0] tg,
                                            input logic [SW-1:0] inc,
                                            input logic          up);
    logic [AW-1:0] sum;
    logic [AW-1:0] lim;
    sum = AW'(cur) + AW'(inc);
    lim = AW'(tg) + AW'(inc);
    if (inc == '0) begin
      return tg;
    end else if (up) begin
      return (sum >= AW'(tg)) ? tg : sum[SW-1:0];
    end else begin
      return (AW'(cur) <= lim) ? tg : (cur - inc);
    end
  endfunction

  assign dwell_new = (set_dwell_i == 32'd0) ? 32'd1 : set_dwell_i;
  assign tgt       = back_q ? start_q : stop_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    step_d  = step_o;
    start_d = start_q;
    stop_d  = stop_q;
    inc_d   = inc_q;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    dir_d   = dir_o;
    back_d  = back_q;
    upd_d   = 1'b0;
    done_d  = 1'b0;

    if (sw_stop_i) begin
      state_d = S_IDLE;
    end else if (sw_start_i) begin
      start_d = set_start_i;
      stop_d  = set_stop_i;
      inc_d   = set_inc_i;
      mode_d  = set_mode_i;
      dwell_d = dwell_new;
      cnt_d   = dwell_new - 32'd1;
      step_d  = set_start_i;
      upd_d   = 1'b1;
      dir_d   = (set_stop_i >= set_start_i);
      back_d  = 1'b0;
      state_d = set_ext_i ? S_ARMED : S_RUN;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (trig_i) state_d = S_RUN;
        end
        S_RUN: begin
          if (cnt_q != 32'd0) begin
            cnt_d = cnt_q - 32'd1;
          end else begin
            cnt_d = dwell_q - 32'd1;
            if (step_o == tgt) begin
              if (mode_q == 2'd1) begin
                step_d = start_q;
              end else if (mode_q == 2'd2) begin
                // Turn around: the first step toward the other end happens now.
                back_d = !back_q;
                dir_d  = !dir_o;
                step_d = advance(step_o, back_q ? stop_q : start_q, inc_q, !dir_o);
              end else begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end
            end else begin
              step_d = advance(step_o, tgt, inc_q, dir_o);
            end
            upd_d = (step_d != step_o);
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge dac_clk_i) begin
    if (!dac_rstn_i) begin
      state_q    <= S_IDLE;
      step_o     <= '0;
      step_upd_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      dir_o      <= 1'b0;
      back_q     <= 1'b0;
      cnt_q      <= '0;
      start_q    <= '0;
      stop_q     <= '0;
      inc_q      <= '0;
      mode_q     <= '0;
      dwell_q    <= '0;
    end else begin
      state_q    <= state_d;
      step_o     <= step_d;
      step_upd_o <= upd_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      dir_o      <= dir_d;
      back_q     <= back_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      inc_q      <= inc_d;
      mode_q     <= mode_d;
      dwell_q    <= dwell_d;
    end
  end

endmodule

// File: tb/tb_red_pitaya_asg_sweep.sv
// Directed testbench for red_pitaya_asg_sweep; expected sequences are hand-derived.
module tb_red_pitaya_asg_sweep;

  localparam int unsigned RSZ = 14;
  localparam int unsigned W   = RSZ + 16;

  logic           dac_clk_i   = 1'b0;
  logic           dac_rstn_i  = 1'b0;
  logic           sw_start_i  = 1'b0;
  logic           sw_stop_i   = 1'b0;
  logic           trig_i      = 1'b0;
  logic           set_ext_i   = 1'b0;
  logic [1:0]     set_mode_i  = 2'd0;
  logic [W-1:0]   set_start_i = '0;
  logic [W-1:0]   set_stop_i  = '0;
  logic [W-1:0]   set_inc_i   = '0;
  logic [31:0]    set_dwell_i = 32'd0;
  logic [W-1:0]   step_o;
  logic           step_upd_o, busy_o, done_o, dir_o;
  logic [W+3:0]   obs;

  int vectors     = 0;
  int miscompares = 0;

  red_pitaya_asg_sweep #(.RSZ(RSZ)) dut (
    .dac_clk_i   (dac_clk_i),
    .dac_rstn_i  (dac_rstn_i),
    .sw_start_i  (sw_start_i),
    .sw_stop_i   (sw_stop_i),
    .trig_i      (trig_i),
    .set_ext_i   (set_ext_i),
    .set_mode_i  (set_mode_i),
    .set_start_i (set_start_i),
    .set_stop_i  (set_stop_i),
    .set_inc_i   (set_inc_i),
    .set_dwell_i (set_dwell_i),
    .step_o      (step_o),
    .step_upd_o  (step_upd_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dir_o       (dir_o)
  );

  always #5 dac_clk_i = ~dac_clk_i;

  // Observed bundle: {step, step_upd, busy, done, dir}
  assign obs = {step_o, step_upd_o, busy_o, done_o, dir_o};

  task automatic tick();
    @(posedge dac_clk_i);
    #1;
  endtask

  task automatic cfg(input logic [W-1:0] s, input logic [W-1:0] p, input logic [W-1:0] i,
                     input logic [31:0] d, input logic [1:0] m, input logic e);
    set_start_i = s; set_stop_i = p; set_inc_i = i;
    set_dwell_i = d; set_mode_i = m; set_ext_i = e;
  endtask

  task automatic pulse_start();
    sw_start_i = 1'b1;
    tick();
    sw_start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    sw_stop_i = 1'b1;
    tick();
    sw_stop_i = 1'b0;
  endtask

  task automatic test_reset();
    dac_rstn_i = 1'b0;
    tick(); tick();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset got %h want %h", obs, {(W+4){1'b0}});
    end
    dac_rstn_i = 1'b1;
    tick();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_release got %h want %h", obs, {(W+4){1'b0}});
    end
  endtask

  task automatic test_single_up();
    logic [W+3:0] exp;
    int upd_cnt;
    upd_cnt = 0;
    cfg(W'(32'h10000), W'(32'h50000), W'(32'h10000), 32'd4, 2'd0, 1'b0);
    pulse_start();
    for (int k = 0; k <= 20; k++) begin
      if (k < 20) exp = {W'((k / 4 + 1) * 32'h10000), (k % 4) == 0, 1'b1, 1'b0, 1'b1};
      else        exp = {W'(32'h50000), 1'b0, 1'b0, 1'b1, 1'b1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL single_up k=%0d got %h want %h", k, obs, exp);
      end
      upd_cnt += int'(step_upd_o);
      tick();
    end
    vectors++;
    if (upd_cnt != 5) begin
      miscompares++;
      $display("FAIL single_up_upd_count got %0d want 5", upd_cnt);
    end
    vectors++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_up_after got done=%b busy=%b want 0 0", done_o, busy_o);
    end
  endtask

  task automatic test_single_down();
    logic [W-1:0] seq [5];
    logic [W+3:0] exp;
    seq = '{W'(32'h50000), W'(32'h40000), W'(32'h30000), W'(32'h20000), W'(32'h18000)};
    cfg(W'(32'h50000), W'(32'h18000), W'(32'h10000), 32'd1, 2'd0, 1'b0);
    pulse_start();
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) exp = {seq[k], 1'b1, 1'b1, 1'b0, 1'b0};
      else       exp = {W'(32'h18000), 1'b0, 1'b0, 1'b1, 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL single_down k=%0d got %h want %h", k, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_triangle();
    int tri_seq [4];
    logic [W+3:0] exp;
    int j, p;
    tri_seq = '{1, 2, 3, 2};
    cfg(W'(32'h10000), W'(32'h30000), W'(32'h10000), 32'd2, 2'd2, 1'b0);
    pulse_start();
    for (int k = 0; k < 26; k++) begin
      j = k / 2;
      p = j % 4;
      exp = {W'(tri_seq[p] * 32'h10000), (k % 2) == 0, 1'b1, 1'b0,
             (p == 1) || (p == 2) || (j == 0)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL triangle k=%0d got %h want %h", k, obs, exp);
      end
      tick();
    end
    pulse_stop();
  endtask

  task automatic test_ext_saw();
    logic [W+3:0] exp;
    cfg(W'(32'h10000), W'(32'h30000), W'(32'h10000), 32'd3, 2'd1, 1'b1);
    pulse_start();
    for (int k = 0; k < 100; k++) begin
      exp = {W'(32'h10000), k == 0, 1'b1, 1'b0, 1'b1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL ext_armed k=%0d got %h want %h", k, obs, exp);
      end
      tick();
    end
    trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    for (int k = 0; k < 15; k++) begin
      exp = {W'((1 + (k / 3) % 3) * 32'h10000), (k % 3 == 0) && (k > 0), 1'b1, 1'b0, 1'b1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL ext_saw k=%0d got %h want %h", k, obs, exp);
      end
      tick();
    end
    pulse_stop();
  endtask

  task automatic test_stop_mid_run();
    logic [W+3:0] exp;
    cfg(W'(32'h10000), W'(32'h50000), W'(32'h10000), 32'd2, 2'd0, 1'b0);
    pulse_start();
    repeat (4) tick();
    vectors++;
    if (step_o !== W'(32'h30000)) begin
      miscompares++;
      $display("FAIL stop_pre got %h want %h", step_o, W'(32'h30000));
    end
    pulse_stop();
    exp = {W'(32'h30000), 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL stop_mid_run k=%0d got %h want %h", k, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_start_stop_same();
    logic [W+3:0] exp;
    cfg(W'(32'h70000), W'(32'h10000), W'(32'h10000), 32'd1, 2'd1, 1'b0);
    sw_start_i = 1'b1;
    sw_stop_i  = 1'b1;
    tick();
    sw_start_i = 1'b0;
    sw_stop_i  = 1'b0;
    exp = {W'(32'h30000), 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL start_stop_same k=%0d got %h want %h", k, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_dwell_zero();
    logic [W+3:0] exp;
    cfg(W'(32'h10000), W'(32'h30000), W'(32'h10000), 32'd0, 2'd0, 1'b0);
    pulse_start();
    for (int k = 0; k <= 3; k++) begin
      if (k < 3) exp = {W'((k + 1) * 32'h10000), 1'b1, 1'b1, 1'b0, 1'b1};
      else       exp = {W'(32'h30000), 1'b0, 1'b0, 1'b1, 1'b1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL dwell_zero k=%0d got %h want %h", k, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_equal_endpoints();
    logic [W+3:0] exp;
    cfg(W'(32'h20000), W'(32'h20000), W'(32'h10000), 32'd3, 2'd0, 1'b0);
    pulse_start();
    for (int k = 0; k <= 3; k++) begin
      if (k < 3) exp = {W'(32'h20000), k == 0, 1'b1, 1'b0, 1'b1};
      else       exp = {W'(32'h20000), 1'b0, 1'b0, 1'b1, 1'b1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL equal_single k=%0d got %h want %h", k, obs, exp);
      end
      tick();
    end
    cfg(W'(32'h20000), W'(32'h20000), W'(32'h10000), 32'd1, 2'd2, 1'b0);
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (step_o !== W'(32'h20000) || step_upd_o !== (k == 0) || busy_o !== 1'b1 || done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL equal_tri k=%0d got step=%h upd=%b busy=%b done=%b want step=20000 upd=%b busy=1 done=0",
                 k, step_o, step_upd_o, busy_o, done_o, k == 0);
      end
      tick();
    end
    pulse_stop();
  endtask

  task automatic test_inc_zero();
    logic [W+3:0] exp;
    cfg(W'(32'h10000), W'(32'h40000), W'(32'h0), 32'd1, 2'd0, 1'b0);
    pulse_start();
    for (int k = 0; k <= 2; k++) begin
      case (k)
        0:       exp = {W'(32'h10000), 1'b1, 1'b1, 1'b0, 1'b1};
        1:       exp = {W'(32'h40000), 1'b1, 1'b1, 1'b0, 1'b1};
        default: exp = {W'(32'h40000), 1'b0, 1'b0, 1'b1, 1'b1};
      endcase
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL inc_zero k=%0d got %h want %h", k, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_run();
    cfg(W'(32'h10000), W'(32'h30000), W'(32'h10000), 32'd1, 2'd2, 1'b0);
    pulse_start();
    repeat (5) tick();
    dac_rstn_i = 1'b0;
    tick();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_run got %h want %h", obs, {(W+4){1'b0}});
    end
    dac_rstn_i = 1'b1;
    trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    tick();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL idle_trig_ignored got %h want %h", obs, {(W+4){1'b0}});
    end
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_single_down();
    test_triangle();
    test_ext_saw();
    test_stop_mid_run();
    test_start_stop_same();
    test_dwell_zero();
    test_equal_endpoints();
    test_inc_zero();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
